// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: triggers an image sensor, waits for each frame,
// forwards its pixels with SOF/EOL/EOF markers and checks frame geometry.
// Captures n_frames frames per start request; abort or reset drop the capture.
module frame_capture_ctrl #(
  parameter int N_COL    = 640,
  parameter int N_LINE   = 480,
  parameter int TRIG_LEN = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic        pixel_clock,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  n_frames,
  input  logic        frame_valid,
  input  logic        line_valid,
  input  logic [15:0] data,
  output logic        frame_trigger,
  output logic        pix_valid,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic [15:0] pix_data,
  output logic        busy,
  output logic        done,
  output logic        err_geom,
  output logic        err_timeout,
  output logic [7:0]  frame_cnt
);

  localparam int TRIG_W = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [15:0]       COL_LAST  = 16'(N_COL - 1);
  localparam logic [15:0]       COL_FULL  = 16'(N_COL);
  localparam logic [15:0]       LINE_LAST = 16'(N_LINE - 1);
  localparam logic [15:0]       LINE_FULL = 16'(N_LINE);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_FV,
    ACTIVE,
    CHECK,
    DONE
  } state_t;

  state_t            state, state_d;
  logic [TRIG_W-1:0] trig_cnt;
  logic [TO_W-1:0]   wait_cnt;
  logic [15:0]       col_cnt;
  logic [15:0]       line_cnt;
  logic [15:0]       line_cnt_eff;
  logic [7:0]        n_frames_q;
  logic              fv_q, lv_q;
  logic              sof_pend;
  logic              fv_rise, fv_fall, lv_fall;
  logic              pixel;
  logic              start_ok;

  // Sensor framing edges are taken against the previous cycle's level, so a
  // frame_valid that is already high when we start waiting is not a rise.
  assign fv_rise  = frame_valid & ~fv_q;
  assign fv_fall  = ~frame_valid & fv_q;
  assign lv_fall  = ~line_valid & lv_q;
  assign start_ok = start && (n_frames != 8'd0);

  // A pixel is captured only in ACTIVE, and never in the cycle abort is seen.
  assign pixel = (state == ACTIVE) && frame_valid && line_valid && !abort;

  // Line count including a line ending this very cycle, so a frame_valid
  // fall coincident with the last line_valid fall is judged correctly.
  assign line_cnt_eff = line_cnt + {15'd0, lv_fall};

  assign frame_trigger = (state == TRIG);
  assign busy          = (state != IDLE) && (state != DONE);
  assign done          = (state == DONE);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic; abort from any busy state wins over normal progress.
  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start_ok) state_d = TRIG;
      TRIG:    if (trig_cnt == TRIG_LAST) state_d = WAIT_FV;
      WAIT_FV: begin
        if (fv_rise)                  state_d = ACTIVE;
        else if (wait_cnt == TO_LAST) state_d = DONE;
      end
      ACTIVE:  if (fv_fall) state_d = CHECK;
      CHECK:   state_d = (frame_cnt + 8'd1 == n_frames_q) ? DONE : TRIG;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state != IDLE)) state_d = IDLE;
  end

  // Counters, frame bookkeeping and sticky error flags.
  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) begin
      fv_q        <= 1'b0;
      lv_q        <= 1'b0;
      trig_cnt    <= '0;
      wait_cnt    <= '0;
      col_cnt     <= '0;
      line_cnt    <= '0;
      n_frames_q  <= '0;
      frame_cnt   <= '0;
      sof_pend    <= 1'b0;
      err_geom    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      fv_q     <= frame_valid;
      lv_q     <= line_valid;
      trig_cnt <= (state == TRIG && state_d == TRIG) ? trig_cnt + TRIG_W'(1) : '0;
      wait_cnt <= (state == WAIT_FV && state_d == WAIT_FV) ? wait_cnt + TO_W'(1) : '0;

      case (state)
        IDLE: begin
          if (start_ok) begin
            n_frames_q  <= n_frames;
            frame_cnt   <= '0;
            err_geom    <= 1'b0;
            err_timeout <= 1'b0;
          end
        end
        WAIT_FV: begin
          if (!abort) begin
            if (fv_rise) begin
              col_cnt  <= '0;
              line_cnt <= '0;
              sof_pend <= 1'b1;
            end else if (wait_cnt == TO_LAST) begin
              err_timeout <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (!abort) begin
            if (pixel) begin
              sof_pend <= 1'b0;
              if (col_cnt != 16'hFFFF) col_cnt <= col_cnt + 16'd1;
            end
            if (lv_fall) begin
              if (col_cnt != COL_FULL) err_geom <= 1'b1;
              line_cnt <= line_cnt + 16'd1;
              col_cnt  <= '0;
            end
            if (fv_fall && (line_cnt_eff != LINE_FULL)) err_geom <= 1'b1;
          end
        end
        CHECK: begin
          if (!abort) frame_cnt <= frame_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Registered pixel output stage: one cycle of latency from the sensor.
  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
      pix_data  <= '0;
    end else begin
      pix_valid <= pixel;
      if (pixel) begin
        pix_data <= data;
        pix_sof  <= sof_pend;
        pix_eol  <= (col_cnt == COL_LAST);
        pix_eof  <= (col_cnt == COL_LAST) && (line_cnt == LINE_LAST);
      end else begin
        pix_sof  <= 1'b0;
        pix_eol  <= 1'b0;
        pix_eof  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Scoreboard bench for frame_capture_ctrl with a scaled-down 8x4 sensor.
// Stimulus pushes expected pixels and completion status into queues; a
// monitor pops and compares whenever the DUT shows pix_valid or done.
module tb_frame_capture_ctrl;

  localparam int N_COL    = 8;
  localparam int N_LINE   = 4;
  localparam int TRIG_LEN = 4;
  localparam int TIMEOUT  = 64;

  logic        pixel_clock = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  n_frames;
  logic        frame_valid, line_valid;
  logic [15:0] data;
  logic        frame_trigger, pix_valid, pix_sof, pix_eol, pix_eof;
  logic [15:0] pix_data;
  logic        busy, done, err_geom, err_timeout;
  logic [7:0]  frame_cnt;

  frame_capture_ctrl #(
    .N_COL(N_COL), .N_LINE(N_LINE), .TRIG_LEN(TRIG_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .pixel_clock(pixel_clock), .rst(rst), .start(start), .abort(abort),
    .n_frames(n_frames), .frame_valid(frame_valid), .line_valid(line_valid),
    .data(data), .frame_trigger(frame_trigger), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .pix_data(pix_data), .busy(busy), .done(done), .err_geom(err_geom),
    .err_timeout(err_timeout), .frame_cnt(frame_cnt)
  );

  always #5 pixel_clock = ~pixel_clock;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } pix_t;

  typedef struct packed {
    logic [7:0] fc;
    logic       eg;
    logic       et;
  } stat_t;

  pix_t  exp_pix[$];
  stat_t exp_done[$];

  int n_vec = 0;
  int n_fail = 0;
  int trig_run = 0, trig_pulses = 0;
  int cnt_pix = 0, cnt_sof = 0, cnt_eol = 0, cnt_eof = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    pix_t  e;
    stat_t s;
    forever begin
      @(posedge pixel_clock);
      #1;
      if (pix_valid === 1'b1) begin
        cnt_pix++;
        if (pix_sof) cnt_sof++;
        if (pix_eol) cnt_eol++;
        if (pix_eof) cnt_eof++;
        if (exp_pix.size() == 0) begin
          check("pix_unexpected", 32'(pix_valid), 32'(0));
        end else begin
          e = exp_pix.pop_front();
          check("pix_data", 32'(pix_data), 32'(e.data));
          check("pix_sof",  32'(pix_sof),  32'(e.sof));
          check("pix_eol",  32'(pix_eol),  32'(e.eol));
          check("pix_eof",  32'(pix_eof),  32'(e.eof));
        end
      end
      if (done === 1'b1) begin
        if (exp_done.size() == 0) begin
          check("done_unexpected", 32'(done), 32'(0));
        end else begin
          s = exp_done.pop_front();
          check("done_frame_cnt",   32'(frame_cnt),   32'(s.fc));
          check("done_err_geom",    32'(err_geom),    32'(s.eg));
          check("done_err_timeout", 32'(err_timeout), 32'(s.et));
        end
      end
      if (frame_trigger === 1'b1) begin
        trig_run++;
      end else if (trig_run != 0) begin
        check("trig_width", 32'(trig_run), 32'(TRIG_LEN));
        trig_pulses++;
        trig_run = 0;
      end
    end
  end

  task automatic push_pix(input logic [15:0] d, input logic sof, input logic eol, input logic eof);
    pix_t e;
    e.data = d;
    e.sof  = sof;
    e.eol  = eol;
    e.eof  = eof;
    exp_pix.push_back(e);
  endtask

  task automatic push_done(input logic [7:0] fc, input logic eg, input logic et);
    stat_t s;
    s.fc = fc;
    s.eg = eg;
    s.et = et;
    exp_done.push_back(s);
  endtask

  task automatic do_start(input logic [7:0] n, input logic with_abort);
    @(negedge pixel_clock);
    start    = 1'b1;
    n_frames = n;
    abort    = with_abort;
    @(negedge pixel_clock);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_trig_end();
    bit seen = 1'b0;
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pixel_clock);
      if (frame_trigger) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("trig_wait_expired", 32'(ok), 32'(1));
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge pixel_clock);
      if (exp_done.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("done_wait_expired", 32'(ok), 32'(1));
      exp_done.delete();
    end
  endtask

  // One sensor frame; lens[l] pixels on line l, 2-cycle blanking throughout.
  task automatic drive_frame(input int lens[N_LINE], input logic [15:0] base);
    bit first = 1'b1;
    @(negedge pixel_clock);
    frame_valid = 1'b1;
    line_valid  = 1'b0;
    @(negedge pixel_clock);
    for (int l = 0; l < N_LINE; l++) begin
      for (int c = 0; c < lens[l]; c++) begin
        @(negedge pixel_clock);
        line_valid = 1'b1;
        data       = base + 16'(l * 16 + c);
        push_pix(data, first, c == N_COL - 1, (c == N_COL - 1) && (l == N_LINE - 1));
        first = 1'b0;
      end
      @(negedge pixel_clock);
      line_valid = 1'b0;
      data       = '0;
      @(negedge pixel_clock);
    end
    @(negedge pixel_clock);
    frame_valid = 1'b0;
    @(negedge pixel_clock);
    @(negedge pixel_clock);
  endtask

  initial begin : stimulus
    int lens[N_LINE];
    int k;

    rst = 1'b1; start = 1'b0; abort = 1'b0; n_frames = '0;
    frame_valid = 1'b0; line_valid = 1'b0; data = '0;

    // Reset state
    #1;
    check("rst_busy",        32'(busy),          32'(0));
    check("rst_done",        32'(done),          32'(0));
    check("rst_trigger",     32'(frame_trigger), 32'(0));
    check("rst_pix_valid",   32'(pix_valid),     32'(0));
    check("rst_pix_data",    32'(pix_data),      32'(0));
    check("rst_err_geom",    32'(err_geom),      32'(0));
    check("rst_err_timeout", 32'(err_timeout),   32'(0));
    check("rst_frame_cnt",   32'(frame_cnt),     32'(0));
    repeat (3) @(negedge pixel_clock);
    rst = 1'b0;

    // start with n_frames=0 is ignored
    do_start(8'd0, 1'b0);
    check("zero_frames_busy", 32'(busy), 32'(0));

    // Two clean frames
    cnt_pix = 0; cnt_sof = 0; cnt_eol = 0; cnt_eof = 0;
    lens = '{8, 8, 8, 8};
    push_done(8'd2, 1'b0, 1'b0);
    do_start(8'd2, 1'b0);
    check("busy_after_start", 32'(busy), 32'(1));
    wait_trig_end();
    drive_frame(lens, 16'h1000);
    wait_trig_end();
    drive_frame(lens, 16'h2000);
    wait_done();
    check("two_frames_pix_cnt", 32'(cnt_pix), 32'(64));
    check("two_frames_sof_cnt", 32'(cnt_sof), 32'(2));
    check("two_frames_eol_cnt", 32'(cnt_eol), 32'(8));
    check("two_frames_eof_cnt", 32'(cnt_eof), 32'(2));
    check("two_frames_frame_cnt", 32'(frame_cnt), 32'(2));
    check("two_frames_idle", 32'(busy), 32'(0));

    // Silent sensor: timeout exactly TRIG_LEN+TIMEOUT edges after start
    push_done(8'd0, 1'b0, 1'b1);
    do_start(8'd1, 1'b0);
    k = 0;
    for (int i = 1; i <= TRIG_LEN + TIMEOUT + 20; i++) begin
      @(posedge pixel_clock);
      #1;
      if (err_timeout) begin
        k = i;
        break;
      end
    end
    check("timeout_cycles", 32'(k), 32'(TRIG_LEN + TIMEOUT));
    wait_done();

    // Geometry errors: a 9-pixel and a 7-pixel line; capture still completes
    lens = '{8, 9, 7, 8};
    push_done(8'd1, 1'b1, 1'b0);
    do_start(8'd1, 1'b0);
    wait_trig_end();
    drive_frame(lens, 16'h3000);
    wait_done();

    // frame_valid already high at start: only the next frame is captured
    lens = '{8, 8, 8, 8};
    push_done(8'd1, 1'b0, 1'b0);
    @(negedge pixel_clock);
    frame_valid = 1'b1;
    do_start(8'd1, 1'b0);
    for (int i = 0; i < TRIG_LEN + 6; i++) begin
      @(negedge pixel_clock);
      line_valid = (i % 3 != 0);
      data       = 16'hBAD0 + 16'(i);
    end
    check("stale_fv_still_waiting", 32'(busy), 32'(1));
    check("stale_fv_no_pixel", 32'(pix_valid), 32'(0));
    @(negedge pixel_clock);
    frame_valid = 1'b0;
    line_valid  = 1'b0;
    data        = '0;
    drive_frame(lens, 16'h4000);
    wait_done();

    // Abort mid-line during frame 1 of 3
    do_start(8'd3, 1'b0);
    wait_trig_end();
    @(negedge pixel_clock);
    frame_valid = 1'b1;
    @(negedge pixel_clock);
    for (int c = 0; c < N_COL; c++) begin
      @(negedge pixel_clock);
      line_valid = 1'b1;
      data       = 16'h6000 + 16'(c);
      push_pix(data, c == 0, c == N_COL - 1, 1'b0);
    end
    @(negedge pixel_clock);
    line_valid = 1'b0;
    @(negedge pixel_clock);
    for (int c = 0; c < 3; c++) begin
      @(negedge pixel_clock);
      line_valid = 1'b1;
      data       = 16'h6010 + 16'(c);
      push_pix(data, 1'b0, 1'b0, 1'b0);
    end
    @(negedge pixel_clock);
    data  = 16'h60FF;
    abort = 1'b1;
    @(negedge pixel_clock);
    abort = 1'b0; frame_valid = 1'b0; line_valid = 1'b0; data = '0;
    check("abort_busy",      32'(busy),          32'(0));
    check("abort_pix_valid", 32'(pix_valid),     32'(0));
    check("abort_trigger",   32'(frame_trigger), 32'(0));
    check("abort_frame_cnt", 32'(frame_cnt),     32'(0));
    repeat (10) @(negedge pixel_clock);

    // Restart after abort, with abort asserted alongside start in IDLE
    push_done(8'd1, 1'b0, 1'b0);
    do_start(8'd1, 1'b1);
    check("start_beats_abort", 32'(busy), 32'(1));
    wait_trig_end();
    drive_frame(lens, 16'h7000);
    wait_done();

    // Reset asserted mid-ACTIVE while a pixel is on the output
    do_start(8'd1, 1'b0);
    wait_trig_end();
    @(negedge pixel_clock);
    frame_valid = 1'b1;
    @(negedge pixel_clock);
    for (int c = 0; c < 5; c++) begin
      @(negedge pixel_clock);
      line_valid = 1'b1;
      data       = 16'h8000 + 16'(c);
      push_pix(data, c == 0, 1'b0, 1'b0);
    end
    @(posedge pixel_clock);
    #3;
    check("pre_rst_pix_valid", 32'(pix_valid), 32'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_busy",      32'(busy),          32'(0));
    check("mid_rst_pix_valid", 32'(pix_valid),     32'(0));
    check("mid_rst_pix_data",  32'(pix_data),      32'(0));
    check("mid_rst_trigger",   32'(frame_trigger), 32'(0));
    check("mid_rst_frame_cnt", 32'(frame_cnt),     32'(0));
    frame_valid = 1'b0; line_valid = 1'b0; data = '0;
    repeat (2) @(negedge pixel_clock);
    rst = 1'b0;
    repeat (20) @(negedge pixel_clock);
    check("post_rst_idle", 32'(busy), 32'(0));

    // Leftovers and trigger count (2+1+1+1+1+1+1)
    check("pix_queue_empty",  32'(exp_pix.size()),  32'(0));
    check("done_queue_empty", 32'(exp_done.size()), 32'(0));
    check("trigger_pulses",   32'(trig_pulses),     32'(8));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameter N_COL, default 640, active pixels per line.
REQ-002 SHALL have parameter N_LINE, default 480, lines per frame.
REQ-003 SHALL have parameter TRIG_LEN, default 4, frame_trigger pulse width in cycles.
REQ-004 SHALL have parameter TIMEOUT, default 4096, max cycles from trigger end to frame start.
REQ-005 pixel_clock  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  one-cycle request to capture n_frames frames.
REQ-008 abort  in  1  synchronous abort of a capture in progress.
REQ-009 n_frames  in  8  frame count, sampled when start is accepted.
REQ-010 frame_valid, line_valid  in  1 each  sensor framing, synchronous to pixel_clock.
REQ-011 data  in  16  sensor pixel word.
REQ-012 frame_trigger  out  1  sensor trigger pulse.
REQ-013 pix_valid, pix_sof, pix_eol, pix_eof  out  1 each  output pixel strobe and markers.
REQ-014 pix_data  out  16  output pixel word.
REQ-015 busy, done  out  1 each  capture active; one-cycle completion pulse.
REQ-016 err_geom, err_timeout  out  1 each  sticky error flags.
REQ-017 frame_cnt  out  8  frames completed in current capture.

Function
REQ-018 FSM states SHALL be IDLE, TRIG, WAIT_FV, ACTIVE, CHECK, DONE.
REQ-019 IDLE: start=1 with n_frames!=0 -> TRIG; latch n_frames; clear frame_cnt, err_geom, err_timeout; start with n_frames=0 ignored.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 TRIG: frame_trigger=1 for exactly TRIG_LEN cycles, then -> WAIT_FV; frame_trigger=0 in all other states.
REQ-022 WAIT_FV: frame_valid rising edge (prev 0, now 1) -> ACTIVE; frame_valid already high on entry SHALL NOT count as a start.
REQ-023 WAIT_FV: TIMEOUT cycles without rising edge -> set err_timeout, -> DONE.
REQ-024 ACTIVE: cycle with frame_valid&line_valid=1 is a pixel; col_cnt increments per pixel.
REQ-025 line_valid falling edge in ACTIVE: col_cnt!=N_COL sets err_geom; line_cnt increments; col_cnt clears.
REQ-026 frame_valid falling edge in ACTIVE -> CHECK; line_cnt!=N_LINE sets err_geom.
REQ-027 CHECK (one cycle): frame_cnt increments; frame_cnt+1==latched n_frames -> DONE, else -> TRIG.
REQ-028 DONE (one cycle): done=1, -> IDLE; busy=1 in all states except IDLE and DONE.
REQ-029 Geometry error SHALL NOT stop capture; remaining frames proceed.
REQ-030 Pixel output latency exactly 1 cycle: pix_valid, pix_data registered from ACTIVE-state pixels only.
REQ-031 pix_sof with first pixel of frame; pix_eol with pixel where col_cnt==N_COL-1; pix_eof with pix_eol when line_cnt==N_LINE-1.
REQ-032 Pixels beyond N_COL per line still output with pix_eol=0; col_cnt saturates at 2**16-1.
REQ-033 abort=1 in any non-IDLE state -> IDLE next cycle; frame_trigger, pix_valid drop immediately (next edge); done not pulsed; error flags and frame_cnt retained.
REQ-034 abort and start same cycle in IDLE: start accepted, abort ignored.

Reset
REQ-035 rst=1 SHALL force asynchronously: state IDLE, all counters 0, frame_trigger=0, pix_*=0, pix_data=0, busy=0, done=0, err_geom=0, err_timeout=0, frame_cnt=0.
REQ-036 Reset mid-capture SHALL discard capture; no done pulse after release.

Verification
REQ-037 start, n_frames=2, sensor 640x480, 689-cycle vsync, 25-cycle hsync -> two 4-cycle triggers, 614400 pix_valid, 2 pix_sof, 960 pix_eol, 2 pix_eof, frame_cnt=2, done once, no errors.
REQ-038 start, n_frames=1, sensor silent -> err_timeout=1 exactly TRIG_LEN+TIMEOUT cycles after start, done pulse, frame_cnt=0.
REQ-039 One line of 639 pixels in frame -> err_geom=1, done still pulses, frame_cnt=1.
REQ-040 Capture started with frame_valid already high -> first pixel output only after next frame_valid rise; pix_data equals data 1 cycle earlier.
REQ-041 abort mid-line during frame 1 of 3 -> busy=0 and pix_valid=0 next cycle, no done, frame_cnt=0; new start accepted afterward.
REQ-042 rst asserted mid-ACTIVE -> all outputs 0 immediately, IDLE after release, no done.
